// File: rtl/split_4o.sv
`default_nettype none
// ============================================================================
// Module   : split_4o
// Brief    : De-concatenates a serial filter-concat stream into four branch
//            outputs and flags the last word of each IMG_WIDTH x IMG_WIDTH frame.
// Revision : 1.0  initial release
// ============================================================================
module split_4o #(
    parameter int IMG_WIDTH  = 35,
    parameter int N1         = 1,
    parameter int N2         = 1,
    parameter int N3         = 1,
    parameter int N4         = 1,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    output logic [DATA_WIDTH-1:0] pxl_out_1,
    output logic [DATA_WIDTH-1:0] pxl_out_2,
    output logic [DATA_WIDTH-1:0] pxl_out_3,
    output logic [DATA_WIDTH-1:0] pxl_out_4,
    output logic                  valid_out_1,
    output logic                  valid_out_2,
    output logic                  valid_out_3,
    output logic                  valid_out_4,
    output logic                  frame_done
);

    localparam int c_T     = N1 + N2 + N3 + N4;
    localparam int c_FRAME = IMG_WIDTH * IMG_WIDTH;
    localparam int c_W_W   = (c_T > 1) ? $clog2(c_T) : 1;
    localparam int c_P_W   = (c_FRAME > 1) ? $clog2(c_FRAME) : 1;

    localparam logic [c_W_W-1:0] c_B1     = c_W_W'(N1);
    localparam logic [c_W_W-1:0] c_B2     = c_W_W'(N1 + N2);
    localparam logic [c_W_W-1:0] c_B3     = c_W_W'(N1 + N2 + N3);
    localparam logic [c_W_W-1:0] c_W_LAST = c_W_W'(c_T - 1);
    localparam logic [c_P_W-1:0] c_P_LAST = c_P_W'(c_FRAME - 1);

    logic [c_W_W-1:0]      r_w;
    logic [c_P_W-1:0]      r_p;
    logic [DATA_WIDTH-1:0] r_pxl_1, r_pxl_2, r_pxl_3, r_pxl_4;
    logic [3:0]            r_valid;
    logic                  r_frame_done;

    logic [3:0]            w_sel;
    logic                  w_last_word;
    logic                  w_last_pos;

    // Branch boundaries are cumulative word offsets within one position.
    always_comb begin
        w_sel = 4'b1000;
        if (r_w < c_B1) begin
            w_sel = 4'b0001;
        end else if (r_w < c_B2) begin
            w_sel = 4'b0010;
        end else if (r_w < c_B3) begin
            w_sel = 4'b0100;
        end
    end

    assign w_last_word = (r_w == c_W_LAST);
    assign w_last_pos  = (r_p == c_P_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_w          <= '0;
            r_p          <= '0;
            r_pxl_1      <= '0;
            r_pxl_2      <= '0;
            r_pxl_3      <= '0;
            r_pxl_4      <= '0;
            r_valid      <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_valid      <= '0;
            r_frame_done <= 1'b0;
            if (valid_in) begin
                r_valid <= w_sel;
                if (w_sel[0]) r_pxl_1 <= pxl_in;
                if (w_sel[1]) r_pxl_2 <= pxl_in;
                if (w_sel[2]) r_pxl_3 <= pxl_in;
                if (w_sel[3]) r_pxl_4 <= pxl_in;
                if (w_last_word) begin
                    r_w <= '0;
                    if (w_last_pos) begin
                        r_p          <= '0;
                        r_frame_done <= 1'b1;
                    end else begin
                        r_p <= r_p + 1'b1;
                    end
                end else begin
                    r_w <= r_w + 1'b1;
                end
            end
        end
    end

    assign pxl_out_1   = r_pxl_1;
    assign pxl_out_2   = r_pxl_2;
    assign pxl_out_3   = r_pxl_3;
    assign pxl_out_4   = r_pxl_4;
    assign valid_out_1 = r_valid[0];
    assign valid_out_2 = r_valid[1];
    assign valid_out_3 = r_valid[2];
    assign valid_out_4 = r_valid[3];
    assign frame_done  = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_split_4o.sv
`default_nettype none
// ============================================================================
// Module   : tb_split_4o
// Brief    : Directed self-checking bench for split_4o, two configurations.
// Revision : 1.0  initial release
// ============================================================================
module tb_split_4o;

    logic        clk = 1'b0;
    logic        reset;
    logic        va, vb;
    logic [31:0] da, db;

    logic [31:0] pa [4];
    logic [31:0] pb [4];
    logic        vo_a [4];
    logic        vo_b [4];
    logic        fd_a, fd_b;

    int checks = 0;
    int errors = 0;

    // bench-side reference state per instance (0 = A, 1 = B)
    int          nn [2][4] = '{'{1, 1, 1, 1}, '{2, 1, 3, 1}};
    int          mw [2];
    int          mp [2];
    logic [31:0] mpx [2][4];
    logic        mv [2][4];
    logic        mfd [2];
    int          fd_cnt [2];

    logic [31:0] qa [4][$];
    logic [31:0] qb [4][$];

    always #5 clk = ~clk;

    split_4o #(.IMG_WIDTH(3), .N1(1), .N2(1), .N3(1), .N4(1), .DATA_WIDTH(32)) dut_a (
        .clk(clk), .reset(reset), .valid_in(va), .pxl_in(da),
        .pxl_out_1(pa[0]), .pxl_out_2(pa[1]), .pxl_out_3(pa[2]), .pxl_out_4(pa[3]),
        .valid_out_1(vo_a[0]), .valid_out_2(vo_a[1]), .valid_out_3(vo_a[2]),
        .valid_out_4(vo_a[3]), .frame_done(fd_a)
    );

    split_4o #(.IMG_WIDTH(3), .N1(2), .N2(1), .N3(3), .N4(1), .DATA_WIDTH(32)) dut_b (
        .clk(clk), .reset(reset), .valid_in(vb), .pxl_in(db),
        .pxl_out_1(pb[0]), .pxl_out_2(pb[1]), .pxl_out_3(pb[2]), .pxl_out_4(pb[3]),
        .valid_out_1(vo_b[0]), .valid_out_2(vo_b[1]), .valid_out_3(vo_b[2]),
        .valid_out_4(vo_b[3]), .frame_done(fd_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mw[i] = 0; mp[i] = 0; mfd[i] = 1'b0; fd_cnt[i] = 0;
            for (int k = 0; k < 4; k++) begin
                mpx[i][k] = '0; mv[i][k] = 1'b0;
            end
        end
        for (int k = 0; k < 4; k++) begin
            qa[k].delete(); qb[k].delete();
        end
    endtask

    task automatic model_step(input int i, input logic v, input logic [31:0] d);
        int b, t, lim;
        for (int k = 0; k < 4; k++) mv[i][k] = 1'b0;
        mfd[i] = 1'b0;
        if (v) begin
            t = nn[i][0] + nn[i][1] + nn[i][2] + nn[i][3];
            b = 3; lim = 0;
            for (int k = 2; k >= 0; k--) begin
                lim = nn[i][0];
                for (int j = 1; j <= k; j++) lim += nn[i][j];
                if (mw[i] < lim) b = k;
            end
            mpx[i][b] = d;
            mv[i][b]  = 1'b1;
            if (mw[i] == t - 1) begin
                mw[i] = 0;
                if (mp[i] == 8) begin
                    mp[i] = 0; mfd[i] = 1'b1;
                end else begin
                    mp[i]++;
                end
            end else begin
                mw[i]++;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("a_pxl%0d", k + 1), pa[k], mpx[0][k]);
            chk($sformatf("a_vld%0d", k + 1), 32'(vo_a[k]), 32'(mv[0][k]));
            chk($sformatf("b_pxl%0d", k + 1), pb[k], mpx[1][k]);
            chk($sformatf("b_vld%0d", k + 1), 32'(vo_b[k]), 32'(mv[1][k]));
        end
        chk("a_fd", 32'(fd_a), 32'(mfd[0]));
        chk("b_fd", 32'(fd_b), 32'(mfd[1]));
    endtask

    // One clock: drive on falling edge, sample 1 ns after the rising edge.
    task automatic cyc(input logic v0, input logic [31:0] d0, input logic v1, input logic [31:0] d1);
        @(negedge clk);
        va = v0; da = d0; vb = v1; db = d1;
        @(posedge clk);
        model_step(0, v0, d0);
        model_step(1, v1, d1);
        #1;
        check_all();
        for (int k = 0; k < 4; k++) begin
            if (vo_a[k]) qa[k].push_back(pa[k]);
            if (vo_b[k]) qb[k].push_back(pb[k]);
        end
        if (fd_a) fd_cnt[0]++;
        if (fd_b) fd_cnt[1]++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; va = 1'b0; vb = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [31:0] merged [$];
        logic [31:0] src [4][$];
        int          sent_a, sent_b, guard;
        logic        ga, gb;

        reset = 1'b0; va = 1'b0; vb = 1'b0; da = '0; db = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_pxl1", pa[0], 32'h0);
        chk("rst_a_pxl4", pa[3], 32'h0);
        chk("rst_a_vld1", 32'(vo_a[0]), 32'h0);
        chk("rst_b_fd",   32'(fd_b), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // A: 0x10..0x13 back-to-back; B: 0..6 (one full T=7 position)
        for (int i = 0; i < 7; i++) begin
            cyc(i < 4, 32'h10 + 32'(i), 1'b1, 32'(i));
            if (i == 0) chk("a_first_to_out1", pa[0], 32'h10);
            if (i == 3) chk("a_fourth_vld4", 32'(vo_a[3]), 32'h1);
            if (i == 1) chk("b_word1_out1", pb[0], 32'h1);
            if (i == 5) chk("b_word5_out3", pb[2], 32'h5);
        end
        chk("a_out1_final", pa[0], 32'h10);
        chk("a_out2_final", pa[1], 32'h11);
        chk("a_out3_final", pa[2], 32'h12);
        chk("a_out4_final", pa[3], 32'h13);
        chk("b_out2_final", pb[1], 32'h2);
        chk("b_out4_final", pb[3], 32'h6);
        cyc(1'b0, 32'h0, 1'b1, 32'h77);
        chk("b_wrap_to_out1", 32'(vo_b[0]), 32'h1);
        chk("b_wrap_data", pb[0], 32'h77);

        // async reset after 5 words of B, asserted between clock edges
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b0, 32'h0, 1'b1, 32'h100 + 32'(i));
        @(negedge clk);
        reset = 1'b0;
        #1;
        model_reset();
        chk("async_b_pxl3", pb[2], 32'h0);
        chk("async_b_pxl1", pb[0], 32'h0);
        chk("async_b_vld3", 32'(vo_b[2]), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        cyc(1'b0, 32'h0, 1'b1, 32'hABCD);
        chk("after_rst_out1", 32'(vo_b[0]), 32'h1);
        chk("after_rst_data", pb[0], 32'hABCD);

        // full frame on A: 36 words, frame_done only with word 35
        do_reset();
        for (int i = 0; i < 36; i++) begin
            cyc(1'b1, 32'(i), 1'b0, 32'h0);
            if (i == 34) chk("fd_not_early", 32'(fd_a), 32'h0);
        end
        chk("fd_last_word", 32'(fd_a), 32'h1);
        chk("fd_with_vld4", 32'(vo_a[3]), 32'h1);
        chk("fd_data", pa[3], 32'd35);
        cyc(1'b1, 32'd36, 1'b0, 32'h0);
        chk("next_frame_out1", pa[0], 32'd36);
        chk("fd_pulse_one", 32'(fd_a), 32'h0);
        chk("fd_count_1", 32'(fd_cnt[0]), 32'h1);

        // gaps: A two frames of 0..71, B one frame of a merged N=2,1,3,1 stream
        do_reset();
        for (int p = 0; p < 9; p++)
            for (int k = 0; k < 4; k++)
                for (int n = 0; n < nn[1][k]; n++) begin
                    src[k].push_back(32'hB000_0000 | (32'(k) << 16) | 32'(src[k].size()));
                    merged.push_back(src[k][src[k].size() - 1]);
                end
        sent_a = 0; sent_b = 0; guard = 0;
        while ((sent_a < 72 || sent_b < merged.size()) && guard < 2000) begin
            ga = (sent_a < 72) && ($urandom_range(0, 1) == 1);
            gb = (sent_b < merged.size()) && ($urandom_range(0, 1) == 1);
            cyc(ga, 32'(sent_a), gb, gb ? merged[sent_b] : 32'h0);
            if (ga) sent_a++;
            if (gb) sent_b++;
            guard++;
        end
        chk("gap_run_bounded", 32'(guard < 2000), 32'h1);
        cyc(1'b0, 32'h0, 1'b0, 32'h0);
        chk("gap_fd_count_a", 32'(fd_cnt[0]), 32'h2);
        chk("gap_fd_count_b", 32'(fd_cnt[1]), 32'h1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("gap_a_len%0d", k + 1), 32'(qa[k].size()), 32'd18);
            for (int j = 0; j < qa[k].size() && j < 18; j++)
                chk($sformatf("gap_a_b%0d_w%0d", k + 1, j), qa[k][j], 32'(4 * j + k));
            chk($sformatf("rt_b_len%0d", k + 1), 32'(qb[k].size()), 32'(src[k].size()));
            for (int j = 0; j < qb[k].size() && j < src[k].size(); j++)
                chk($sformatf("rt_b_b%0d_w%0d", k + 1, j), qb[k][j], src[k][j]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
